// File: rtl/regfile_mp.sv
// regfile_mp: parametrised general-purpose register file on a single rising
// clock edge. Two registered read ports with write-to-read bypass, one write
// port, a registered output port with a one-cycle valid strobe, and a
// per-register pending scoreboard used by the control unit to stall on loads.
module regfile_mp #(
    parameter int WIDTH   = 16,
    parameter int REGS    = 8,
    parameter int SEL_W   = $clog2(REGS),
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] src_sel,
    input  logic [SEL_W-1:0] dst_sel,
    input  logic             rd_en,
    output logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] dst,
    output logic             src_busy,
    output logic             dst_busy,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             lock_en,
    input  logic [SEL_W-1:0] lock_sel,
    input  logic             out_en,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam bit ZeroR0En = (ZERO_R0 != 0);

    logic [WIDTH-1:0] gpr_q [REGS];
    logic [WIDTH-1:0] gpr_d [REGS];
    logic [REGS-1:0]  pending_q, pending_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic             src_busy_q, src_busy_d;
    logic             dst_busy_q, dst_busy_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             wr_eff;
    logic             lock_eff;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] dst_val;

    // Read value seen by a port: a same-cycle write wins, then the hardwired
    // zero register, then the stored contents.
    function automatic logic [WIDTH-1:0] bypass_value(
        input logic [SEL_W-1:0] sel,
        input logic             we,
        input logic [SEL_W-1:0] wsel,
        input logic [WIDTH-1:0] wdata,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] v;
        if (we && (wsel == sel)) begin
            v = wdata;
        end else if (ZeroR0En && (sel == '0)) begin
            v = '0;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Next-state logic: register writes, scoreboard update (lock beats a
    // returning write), bypassed reads and the output port strobe.
    always_comb begin
        wr_eff      = wr_en && !(ZeroR0En && (wr_sel == '0));
        lock_eff    = lock_en && !(ZeroR0En && (lock_sel == '0));
        gpr_d       = gpr_q;
        pending_d   = pending_q;
        src_d       = src_q;
        dst_d       = dst_q;
        src_busy_d  = src_busy_q;
        dst_busy_d  = dst_busy_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        src_val = bypass_value(src_sel, wr_eff, wr_sel, wr_data, gpr_q[src_sel]);
        dst_val = bypass_value(dst_sel, wr_eff, wr_sel, wr_data, gpr_q[dst_sel]);

        if (wr_eff) begin
            gpr_d[wr_sel]     = wr_data;
            pending_d[wr_sel] = 1'b0;
        end
        if (lock_eff) begin
            pending_d[lock_sel] = 1'b1;
        end

        if (rd_en) begin
            src_d      = src_val;
            dst_d      = dst_val;
            src_busy_d = pending_d[src_sel];
            dst_busy_d = pending_d[dst_sel];
        end

        if (out_en) begin
            out_d       = dst_val;
            out_valid_d = 1'b1;
        end
    end

    // State register with synchronous reset; register 1 resets to all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                gpr_q[i] <= (i == 1) ? '1 : '0;
            end
            pending_q   <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            src_busy_q  <= 1'b0;
            dst_busy_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            gpr_q       <= gpr_d;
            pending_q   <= pending_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            src_busy_q  <= src_busy_d;
            dst_busy_q  <= dst_busy_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign src       = src_q;
    assign dst       = dst_q;
    assign src_busy  = src_busy_q;
    assign dst_busy  = dst_busy_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three builds (default, zero-r0, 32x16) driven by one
// shared stimulus stream and checked every cycle against an array model,
// plus hand-computed literal expectations.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_sel, dst_sel, wr_sel, lock_sel;
    logic        rd_en, wr_en, lock_en, out_en;
    logic [31:0] wr_data;

    logic [15:0] src_a, dst_a, out_a, src_z, dst_z, out_z;
    logic [31:0] src_w, dst_w, out_w;
    logic        sb_a, db_a, ov_a, sb_z, db_z, ov_z, sb_w, db_w, ov_w;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Model state per build: 0 = default, 1 = zero r0, 2 = wide
    logic [31:0] m_gpr  [3][16];
    bit          m_pend [3][16];
    logic [31:0] m_src [3], m_dst [3], m_out [3];
    bit          m_sb [3], m_db [3], m_ov [3];

    logic [31:0] act_src [3], act_dst [3], act_out [3];
    logic        act_sb [3], act_db [3], act_ov [3];

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(16), .REGS(8), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .src_sel(src_sel[2:0]), .dst_sel(dst_sel[2:0]),
        .rd_en(rd_en), .src(src_a), .dst(dst_a), .src_busy(sb_a), .dst_busy(db_a),
        .wr_en(wr_en), .wr_sel(wr_sel[2:0]), .wr_data(wr_data[15:0]),
        .lock_en(lock_en), .lock_sel(lock_sel[2:0]), .out_en(out_en),
        .out(out_a), .out_valid(ov_a));

    regfile_mp #(.WIDTH(16), .REGS(8), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .src_sel(src_sel[2:0]), .dst_sel(dst_sel[2:0]),
        .rd_en(rd_en), .src(src_z), .dst(dst_z), .src_busy(sb_z), .dst_busy(db_z),
        .wr_en(wr_en), .wr_sel(wr_sel[2:0]), .wr_data(wr_data[15:0]),
        .lock_en(lock_en), .lock_sel(lock_sel[2:0]), .out_en(out_en),
        .out(out_z), .out_valid(ov_z));

    regfile_mp #(.WIDTH(32), .REGS(16), .ZERO_R0(0)) dut_w (
        .clk(clk), .rst(rst), .src_sel(src_sel), .dst_sel(dst_sel),
        .rd_en(rd_en), .src(src_w), .dst(dst_w), .src_busy(sb_w), .dst_busy(db_w),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .lock_en(lock_en), .lock_sel(lock_sel), .out_en(out_en),
        .out(out_w), .out_valid(ov_w));

    assign act_src[0] = {16'h0, src_a};
    assign act_src[1] = {16'h0, src_z};
    assign act_src[2] = src_w;
    assign act_dst[0] = {16'h0, dst_a};
    assign act_dst[1] = {16'h0, dst_z};
    assign act_dst[2] = dst_w;
    assign act_out[0] = {16'h0, out_a};
    assign act_out[1] = {16'h0, out_z};
    assign act_out[2] = out_w;
    assign act_sb[0] = sb_a;
    assign act_sb[1] = sb_z;
    assign act_sb[2] = sb_w;
    assign act_db[0] = db_a;
    assign act_db[1] = db_z;
    assign act_db[2] = db_w;
    assign act_ov[0] = ov_a;
    assign act_ov[1] = ov_z;
    assign act_ov[2] = ov_w;

    function automatic int nregs(input int m);
        return (m == 2) ? 16 : 8;
    endfunction

    function automatic logic [31:0] dmask(input int m);
        return (m == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic bit zr(input int m);
        return (m == 1);
    endfunction

    function automatic logic [31:0] read_val(input int m, input int x, input bit we, input int ws);
        if (we && (ws == x)) return wr_data & dmask(m);
        if (zr(m) && (x == 0)) return 32'h0;
        return m_gpr[m][x];
    endfunction

    // One rising edge of every build, computed from the register-file rules
    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            int n = nregs(m);
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_gpr[m][i]  = (i == 1) ? dmask(m) : 32'h0;
                    m_pend[m][i] = 1'b0;
                end
                m_src[m] = 0; m_dst[m] = 0; m_out[m] = 0;
                m_sb[m] = 0; m_db[m] = 0; m_ov[m] = 0;
            end else begin
                int ws = int'(wr_sel) % n;
                int ss = int'(src_sel) % n;
                int ds = int'(dst_sel) % n;
                int ls = int'(lock_sel) % n;
                bit we = wr_en && !(zr(m) && ws == 0);
                bit le = lock_en && !(zr(m) && ls == 0);
                logic [31:0] vs = read_val(m, ss, we, ws);
                logic [31:0] vd = read_val(m, ds, we, ws);
                if (we) begin
                    m_gpr[m][ws]  = wr_data & dmask(m);
                    m_pend[m][ws] = 1'b0;
                end
                if (le) m_pend[m][ls] = 1'b1;
                if (rd_en) begin
                    m_src[m] = vs;
                    m_dst[m] = vd;
                    m_sb[m]  = m_pend[m][ss];
                    m_db[m]  = m_pend[m][ds];
                end
                m_ov[m] = out_en;
                if (out_en) m_out[m] = vd;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare every build against the model on each falling edge
    always @(negedge clk) begin
        if (check_en) begin
            for (int m = 0; m < 3; m++) begin
                checkOutput($sformatf("src[%0d]", m), act_src[m], m_src[m]);
                checkOutput($sformatf("dst[%0d]", m), act_dst[m], m_dst[m]);
                checkOutput($sformatf("out[%0d]", m), act_out[m], m_out[m]);
                checkOutput($sformatf("src_busy[%0d]", m), {31'h0, act_sb[m]}, {31'h0, m_sb[m]});
                checkOutput($sformatf("dst_busy[%0d]", m), {31'h0, act_db[m]}, {31'h0, m_db[m]});
                checkOutput($sformatf("out_valid[%0d]", m), {31'h0, act_ov[m]}, {31'h0, m_ov[m]});
            end
        end
    end

    task automatic clear_inputs();
        rst = 0; rd_en = 0; wr_en = 0; lock_en = 0; out_en = 0;
        src_sel = 0; dst_sel = 0; wr_sel = 0; lock_sel = 0; wr_data = 0;
    endtask

    // Inputs are already set; clock one edge, advance the model, return at negedge
    task automatic applyStimulus();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);

        rst = 1; wr_en = 1; wr_sel = 2; wr_data = 32'h1111_1111;
        applyStimulus();
        check_en = 1'b1;
        checkOutput("reset src", {16'h0, src_a}, 32'h0);
        checkOutput("reset out_valid", {31'h0, ov_a}, 32'h0);

        clear_inputs(); rd_en = 1; src_sel = 1; dst_sel = 0;
        applyStimulus();
        checkOutput("r1 reset value", {16'h0, src_a}, 32'h0000_FFFF);
        checkOutput("r0 reset value", {16'h0, dst_a}, 32'h0);
        checkOutput("r1 wide reset", src_w, 32'hFFFF_FFFF);
        checkOutput("busy after reset", {30'h0, sb_a, db_a}, 32'h0);

        clear_inputs(); wr_en = 1; wr_sel = 3; wr_data = 32'h0000_1234; rd_en = 1; src_sel = 3;
        applyStimulus();
        checkOutput("write bypass", {16'h0, src_a}, 32'h0000_1234);

        clear_inputs(); rd_en = 1; src_sel = 3; dst_sel = 3;
        applyStimulus();
        checkOutput("stored r3 src", {16'h0, src_a}, 32'h0000_1234);
        checkOutput("stored r3 dst", {16'h0, dst_a}, 32'h0000_1234);

        clear_inputs(); lock_en = 1; lock_sel = 5;
        applyStimulus();
        clear_inputs(); rd_en = 1; dst_sel = 5;
        applyStimulus();
        checkOutput("lock busy", {31'h0, db_a}, 32'h1);

        clear_inputs(); wr_en = 1; wr_sel = 5; wr_data = 32'h0000_BEEF; rd_en = 1; dst_sel = 5;
        applyStimulus();
        checkOutput("load return data", {16'h0, dst_a}, 32'h0000_BEEF);
        checkOutput("load return busy", {31'h0, db_a}, 32'h0);

        clear_inputs(); lock_en = 1; lock_sel = 5; wr_en = 1; wr_sel = 5;
        wr_data = 32'h0000_1111; rd_en = 1; dst_sel = 5;
        applyStimulus();
        checkOutput("lock beats write", {31'h0, db_a}, 32'h1);
        checkOutput("lock+write data", {16'h0, dst_a}, 32'h0000_1111);

        clear_inputs(); wr_en = 1; wr_sel = 0; wr_data = 32'h0000_AAAA; lock_en = 1; lock_sel = 0;
        applyStimulus();
        clear_inputs(); rd_en = 1; src_sel = 0; dst_sel = 0;
        applyStimulus();
        checkOutput("zero r0 read", {16'h0, src_z}, 32'h0);
        checkOutput("zero r0 busy", {31'h0, sb_z}, 32'h0);
        checkOutput("plain r0 read", {16'h0, src_a}, 32'h0000_AAAA);
        checkOutput("plain r0 busy", {31'h0, sb_a}, 32'h1);

        clear_inputs(); out_en = 1; dst_sel = 1;
        applyStimulus();
        checkOutput("out data", {16'h0, out_a}, 32'h0000_FFFF);
        checkOutput("out valid pulse", {31'h0, ov_a}, 32'h1);
        clear_inputs();
        applyStimulus();
        checkOutput("out holds", {16'h0, out_a}, 32'h0000_FFFF);
        checkOutput("out valid drops", {31'h0, ov_a}, 32'h0);

        clear_inputs(); out_en = 1; dst_sel = 4; wr_en = 1; wr_sel = 4; wr_data = 32'h0000_4242;
        applyStimulus();
        checkOutput("out bypass", {16'h0, out_a}, 32'h0000_4242);

        clear_inputs(); wr_en = 1; wr_sel = 2; wr_data = 32'h0000_00FF;
        applyStimulus();
        clear_inputs(); rst = 1; wr_en = 1; wr_sel = 2; wr_data = 32'h0000_5555;
        lock_en = 1; lock_sel = 6;
        applyStimulus();
        clear_inputs(); rd_en = 1; src_sel = 2; dst_sel = 5;
        applyStimulus();
        checkOutput("reset drops write", {16'h0, src_a}, 32'h0);
        checkOutput("reset clears pending", {31'h0, db_a}, 32'h0);
        for (int r = 0; r < 16; r++) begin
            clear_inputs(); rd_en = 1; src_sel = 4'(r); dst_sel = 4'(r + 1);
            applyStimulus();
        end

        clear_inputs(); wr_en = 1; wr_sel = 15; wr_data = 32'hDEAD_BEEF;
        applyStimulus();
        clear_inputs(); rd_en = 1; src_sel = 15; dst_sel = 1;
        applyStimulus();
        checkOutput("wide r15", src_w, 32'hDEAD_BEEF);
        checkOutput("wide r1", dst_w, 32'hFFFF_FFFF);
        checkOutput("narrow r7 alias", {16'h0, src_a}, 32'h0000_BEEF);

        for (int i = 0; i < 24; i++) begin
            clear_inputs();
            rst      = (i == 13);
            wr_en    = (i % 3) != 2;
            wr_sel   = 4'(i * 7);
            wr_data  = 32'h1357_9BDF ^ (i * 32'h0101_0111);
            lock_en  = (i % 4) == 1;
            lock_sel = 4'(i * 5 + 1);
            rd_en    = (i % 5) != 4;
            src_sel  = 4'(i * 3);
            dst_sel  = 4'(i * 11 + 2);
            out_en   = (i % 2) == 0;
            applyStimulus();
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the tiny16 general-purpose register file.
- Provides a configurable number of WIDTH-bit registers on a single rising clock edge, replacing the mixed-edge scheme.
- Two registered read ports (src/dst), one write port with write-to-read bypass, and a registered output port with a valid strobe.
- A per-register pending scoreboard flags registers awaiting a load result, so the control unit can stall.

Parameters:
- WIDTH, 16, data width of each register.
- REGS, 8, number of registers; power of two, at least 2.
- SEL_W, $clog2(REGS), width of every select input; derived, not overridden.
- ZERO_R0, 0, when 1 register 0 reads as zero and ignores writes and locks.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- src_sel  input  SEL_W  source read select.
- dst_sel  input  SEL_W  destination read select; also the select for the output port.
- rd_en  input  1  capture src/dst read values this edge.
- src  output  WIDTH  registered source read data.
- dst  output  WIDTH  registered destination read data.
- src_busy  output  1  registered pending flag of the captured src register.
- dst_busy  output  1  registered pending flag of the captured dst register.
- wr_en  input  1  write enable.
- wr_sel  input  SEL_W  write select.
- wr_data  input  WIDTH  write data.
- lock_en  input  1  mark register lock_sel pending (load issued).
- lock_sel  input  SEL_W  register to lock.
- out_en  input  1  capture gpr[dst_sel] to out.
- out  output  WIDTH  registered output data.
- out_valid  output  1  one-cycle pulse on the cycle after out_en.

Behaviour:
- Reset (rst=1 at a rising edge), overriding all other inputs:
  - gpr[1] = all ones; every other gpr = 0.
  - src, dst, out = 0; out_valid, src_busy, dst_busy = 0.
  - All pending bits = 0.
- Write: if wr_en, gpr[wr_sel] <= wr_data and pending[wr_sel] is cleared. When ZERO_R0=1 and wr_sel=0, the write is dropped entirely.
- Lock: if lock_en, pending[lock_sel] is set. It is ignored for register 0 when ZERO_R0=1.
- Lock and write to the same register in the same cycle: the lock wins and pending stays 1 (a new load was issued after the old result returned).
- Read latency is 1 cycle. If rd_en, src/dst <= value(src_sel)/value(dst_sel); otherwise src, dst, src_busy and dst_busy hold.
- value(x) is the bypass value:
  - wr_data if an effective write targets x this cycle;
  - else 0 if ZERO_R0=1 and x=0;
  - else gpr[x].
- src_busy/dst_busy take the next-state pending bit of the selected register (after that cycle's clear and set), captured with rd_en.
- src_sel = dst_sel is legal; both ports return the same value.
- Output port: if out_en, out <= value(dst_sel) and out_valid <= 1; otherwise out holds and out_valid <= 0.
- Out-of-range selects cannot occur because REGS is a power of two.
- Reset asserted mid-operation: any concurrent write, lock or read is discarded that cycle.
- No combinational path exists from any input to any output.

Test Plan:
- Reset, then rd_en with src_sel=1, dst_sel=0 -> next cycle src=16'hFFFF, dst=16'h0000, busy flags 0, out_valid 0.
- wr_en with wr_sel=3, wr_data=16'h1234, plus rd_en with src_sel=3 in the same cycle -> next cycle src=16'h1234 (bypass); a later read of reg 3 also returns 16'h1234.
- lock_en on reg 5, then rd_en with dst_sel=5 -> dst_busy=1. A write of 16'hBEEF to reg 5 with rd_en in the same cycle -> dst=16'hBEEF, dst_busy=0. Lock and write to reg 5 in the same cycle -> dst_busy=1.
- ZERO_R0=1 build: write 16'hAAAA to reg 0 and lock reg 0 -> a read returns 0 with busy 0. With ZERO_R0=0 the same read returns 16'hAAAA.
- out_en with dst_sel=1 after reset -> out=16'hFFFF and out_valid=1 for exactly one cycle; with out_en low afterwards, out holds at 16'hFFFF.
- Write reg 2 = 16'h00FF, then assert rst for one cycle together with wr_en to reg 2 = 16'h5555 -> a read of reg 2 returns 0 and all pending bits are clear.
- Parameter sweep WIDTH=32, REGS=16: write 32'hDEADBEEF to reg 15 -> read-back matches; reg 1 resets to 32'hFFFFFFFF.
